// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_mmio
//  Purpose  : Memory-mapped 8N1 UART transmitter for the picorv32 native
//             memory bus. Decodes a 16-byte window, buffers bytes in a TX
//             FIFO and serialises them at a programmable baud divisor.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   system clock
//    resetn     in   1   synchronous active-low reset
//    mem_valid  in   1   bus request valid
//    mem_instr  in   1   instruction fetch flag (treated as a read)
//    mem_ready  out  1   one-cycle response strobe
//    mem_addr   in  32   byte address
//    mem_wdata  in  32   write data
//    mem_wstrb  in   4   byte write strobes, 0 = read
//    mem_rdata  out 32   read data, zero whenever mem_ready is low
//    uart_tx    out  1   serial line, idles high
//    tx_irq     out  1   high while FIFO empty and shifter idle
//  Register map (offset)
//    0x0 TXDATA  W: push wdata[7:0]       R: 0
//    0x4 STATUS  R: {level, ovf, busy, empty, full}  W: wdata[3]=1 clears ovf
//    0x8 DIV     R/W [15:0], byte-wise
//    0xC reserved, reads 0
// ============================================================================
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        uart_tx,
   output logic        tx_irq
);

   localparam int             PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [15:0]    DIV_RST = 16'(CLK_DIV);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------------
   logic       hit;
   logic       is_write;
   logic [1:0] reg_sel;
   logic       push_req;
   logic       ovf_clr;
   logic       div_wr;

   // The !mem_ready term stops a request that the master still holds during
   // its response cycle from being accepted a second time.
   assign hit      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !mem_ready;
   assign is_write = |mem_wstrb;
   assign reg_sel  = mem_addr[3:2];
   assign push_req = hit && is_write && (reg_sel == 2'd0) && mem_wstrb[0];
   assign ovf_clr  = hit && is_write && (reg_sel == 2'd1) && mem_wstrb[0] && mem_wdata[3];
   assign div_wr   = hit && is_write && (reg_sel == 2'd2);

   // Bits the block has no use for.
   logic unused_bits;
   assign unused_bits = &{1'b0, mem_instr, mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

   // ------------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------------
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   level;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             overflow;

   assign fifo_full  = (level == DEPTH_C);
   assign fifo_empty = (level == '0);
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push       = push_req && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= mem_wdata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push_req && !push) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Baud divisor register
   // ------------------------------------------------------------------------
   logic [15:0] div_q;
   logic [15:0] eff_div;
   logic [15:0] bit_load;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         div_q <= DIV_RST;
      end else if (div_wr) begin
         if (mem_wstrb[0]) begin
            div_q[7:0] <= mem_wdata[7:0];
         end
         if (mem_wstrb[1]) begin
            div_q[15:8] <= mem_wdata[15:8];
         end
      end
   end

   // A divisor of zero runs at one cycle per bit. The divisor is only sampled
   // when a bit period is loaded, so updates land on the next bit boundary.
   assign eff_div  = (div_q == 16'd0) ? 16'd1 : div_q;
   assign bit_load = eff_div - 16'd1;

   // ------------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------------
   state_t      state;
   state_t      state_nx;
   logic [15:0] baud_cnt;
   logic [15:0] baud_nx;
   logic [2:0]  bit_cnt;
   logic [2:0]  bit_nx;
   logic [7:0]  shift;
   logic [7:0]  shift_nx;
   logic        tx_nx;
   logic        bit_end;

   assign bit_end = (baud_cnt == 16'd0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         uart_tx  <= 1'b1;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_nx;
         bit_cnt  <= bit_nx;
         shift    <= shift_nx;
         uart_tx  <= tx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_cnt;
      shift_nx = shift;
      pop      = 1'b0;
      tx_nx    = 1'b1;

      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               shift_nx = fifo_mem[rd_ptr];
               baud_nx  = bit_load;
               state_nx = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               baud_nx  = bit_load;
               bit_nx   = 3'd0;
               state_nx = S_DATA;
            end else begin
               baud_nx = baud_cnt - 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_nx  = bit_load;
               shift_nx = {1'b0, shift[7:1]};
               if (bit_cnt == 3'd7) begin
                  state_nx = S_STOP;
               end else begin
                  bit_nx = bit_cnt + 3'd1;
               end
            end else begin
               baud_nx = baud_cnt - 16'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_nx = bit_load;
               // Chain straight into the next start bit so back-to-back
               // frames have no idle gap.
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  shift_nx = fifo_mem[rd_ptr];
                  state_nx = S_START;
               end else begin
                  state_nx = S_IDLE;
               end
            end else begin
               baud_nx = baud_cnt - 16'd1;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      // The line is registered from the next state so it is glitch-free and
      // aligned with the state it represents.
      case (state_nx)
         S_START: tx_nx = 1'b0;
         S_DATA:  tx_nx = shift_nx[0];
         default: tx_nx = 1'b1;
      endcase
   end

   assign tx_irq = fifo_empty && (state == S_IDLE);

   // ------------------------------------------------------------------------
   // Read mux and response
   // ------------------------------------------------------------------------
   logic [31:0] status;
   logic [31:0] rd_val;

   always_comb begin
      status                = '0;
      status[0]             = fifo_full;
      status[1]             = fifo_empty;
      status[2]             = (state != S_IDLE);
      status[3]             = overflow;
      status[8 +: PTR_W+1]  = level;
      rd_val                = '0;
      case (reg_sel)
         2'd1:    rd_val = status;
         2'd2:    rd_val = {16'd0, div_q};
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= hit;
         mem_rdata <= (hit && !is_write) ? rd_val : 32'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_mmio
//  Purpose  : Self-checking bench for uart_tx_mmio. A line monitor decodes
//             8N1 frames from uart_tx; expected bytes and frame timing come
//             from a queue of written bytes and simple frame arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        uart_tx;
   logic        tx_irq;

   uart_tx_mmio #(
      .BASE_ADDR  (BASE),
      .CLK_DIV    (868),
      .FIFO_DEPTH (8)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_valid (mem_valid),
      .mem_instr (mem_instr),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .uart_tx   (uart_tx),
      .tx_irq    (tx_irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests_run    = 0;
   int tests_failed = 0;
   int req_cyc      = 0;

   // Line monitor state and decoded frames
   bit         mon_en  = 1'b0;
   int         mon_div = 1;
   int         frm_t0[$];
   logic [7:0] frm_byte[$];
   bit         frm_ok[$];
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One bus transaction, picorv32 style. lat = edges until mem_ready (-1 if
   // none within the window); rdata is the response, or the OR of all
   // samples of mem_rdata when no response came.
   task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
      logic [31:0] acc;
      acc       = '0;
      lat       = -1;
      mem_valid = 1'b1;
      mem_instr = (wstrb == 4'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      req_cyc   = cyc;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         if (mem_ready) begin
            lat = i;
            acc = mem_rdata;
            break;
         end
         acc = acc | mem_rdata;
      end
      rdata     = acc;
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_wstrb = 4'd0;
      tick(1);
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] d;
      int          lat;
      bus(BASE + 32'(off), data, strb, d, lat);
      check("wr_latency", 32'(lat), 32'd1);
   endtask

   task automatic rd(input logic [3:0] off, output logic [31:0] data);
      int lat;
      bus(BASE + 32'(off), 32'd0, 4'd0, data, lat);
      check("rd_latency", 32'(lat), 32'd1);
   endtask

   // Cycles until tx_irq rises; -1 when the budget runs out.
   task automatic wait_idle(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (tx_irq) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic clear_frames();
      frm_t0.delete();
      frm_byte.delete();
      frm_ok.delete();
      exp_q.delete();
   endtask

   // Every expected byte must appear, in order, as a well-formed frame, and
   // consecutive frames must start exactly 10*div cycles apart.
   task automatic check_frames(input int d);
      int n;
      check("frame_count", 32'(frm_byte.size()), 32'(exp_q.size()));
      n = (frm_byte.size() < exp_q.size()) ? frm_byte.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check("frame_byte", 32'(frm_byte[i]), 32'(exp_q[i]));
         check("frame_shape", 32'(frm_ok[i]), 32'd1);
         if (i > 0) begin
            check("frame_spacing", 32'(frm_t0[i] - frm_t0[i-1]), 32'(10 * d));
         end
      end
   endtask

   // Frame decoder: a low sample while idle starts a frame; each of the ten
   // bit slots must hold a constant level for mon_div cycles.
   initial begin : line_monitor
      int         t0;
      int         d;
      bit         ok;
      logic [7:0] b;
      logic       cur;
      cur = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && resetn === 1'b1 && uart_tx === 1'b0) begin
            t0 = cyc;
            d  = mon_div;
            ok = 1'b1;
            b  = '0;
            for (int bi = 0; bi < 10; bi++) begin
               for (int k = 0; k < d; k++) begin
                  if (!(bi == 0 && k == 0)) begin
                     @(posedge clk);
                     #1;
                  end
                  if (bi == 0) begin
                     if (uart_tx !== 1'b0) ok = 1'b0;
                  end else if (bi == 9) begin
                     if (uart_tx !== 1'b1) ok = 1'b0;
                  end else begin
                     if (k == 0) cur = uart_tx;
                     else if (uart_tx !== cur) ok = 1'b0;
                     b[bi-1] = cur;
                  end
               end
            end
            frm_t0.push_back(t0);
            frm_byte.push_back(b);
            frm_ok.push_back(ok);
         end
      end
   end

   initial begin : watchdog
      #(3_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [31:0] d;
      logic [31:0] w;
      logic [7:0]  b;
      int          n;
      int          lat;
      int          wcyc;
      int          dv;
      int          cnt;
      int          lows;

      resetn    = 1'b0;
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;

      // ---- Reset state ----
      tick(2);
      resetn = 1'b1;
      check("rst_uart_tx", 32'(uart_tx), 32'd1);
      check("rst_tx_irq", 32'(tx_irq), 32'd1);
      check("rst_ready", 32'(mem_ready), 32'd0);
      rd(4'h4, d);
      check("rst_status", d, 32'h0000_0002);
      rd(4'h8, d);
      check("rst_div", d, 32'd868);

      // ---- Divisor and single frame ----
      wr(4'h8, 32'd4, 4'hF);
      rd(4'h8, d);
      check("div_readback", d, 32'd4);
      clear_frames();
      mon_div = 4;
      mon_en  = 1'b1;
      exp_q.push_back(8'h55);
      wr(4'h0, 32'h0000_0055, 4'h1);
      wcyc = req_cyc;
      check("irq_after_push", 32'(tx_irq), 32'd0);
      tick(20);
      check("irq_mid_frame", 32'(tx_irq), 32'd0);
      wait_idle(200, n);
      // Frame starts on the cycle the write returns, so 40 - 20 remain.
      check("single_frame_end", 32'(n), 32'd20);
      tick(2);
      check_frames(4);
      if (frm_t0.size() > 0) begin
         check("start_latency", 32'(frm_t0[0] - wcyc), 32'd2);
      end

      // ---- Back-to-back frames ----
      clear_frames();
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back(8'(i));
         wr(4'h0, 32'(i), 4'h1);
      end
      wait_idle(400, n);
      // Three writes take 6 cycles of the 2 + 120 until the line is idle.
      check("b2b_end", 32'(n), 32'd116);
      tick(2);
      check_frames(4);
      rd(4'h4, d);
      check("b2b_status", d, 32'h0000_0002);

      // ---- Randomized bursts against the byte-queue model ----
      for (int r = 0; r < 6; r++) begin
         dv = $urandom_range(1, 5);
         wr(4'h8, 32'(dv), 4'h3);
         mon_div = dv;
         clear_frames();
         cnt = $urandom_range(1, 9);
         for (int i = 0; i < cnt; i++) begin
            w      = $urandom();
            b      = 8'($urandom_range(0, 255));
            w[7:0] = b;
            exp_q.push_back(b);
            wr(4'h0, w, 4'h1);
         end
         wait_idle(1000, n);
         check("rnd_idle", 32'(n > 0), 32'd1);
         tick(2);
         check_frames(dv);
         rd(4'h4, d);
         check("rnd_status", d, 32'h0000_0002);
      end

      // ---- Overflow ----
      wr(4'h8, 32'd64, 4'h3);
      mon_div = 64;
      clear_frames();
      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom_range(0, 255));
         if (i < 9) exp_q.push_back(b);
         wr(4'h0, {24'd0, b}, 4'h1);
      end
      rd(4'h4, d);
      check("ovf_status", d, 32'h0000_080D);
      wr(4'h4, 32'h0000_0008, 4'h1);
      rd(4'h4, d);
      check("ovf_cleared", d, 32'h0000_0805);
      wait_idle(8000, n);
      check("ovf_idle", 32'(n > 0), 32'd1);
      tick(2);
      check_frames(64);

      // ---- Decode and byte strobes ----
      bus(BASE + 32'h10, 32'd0, 4'd0, d, lat);
      check("oow_above_ready", 32'(lat), 32'hFFFF_FFFF);
      check("oow_above_rdata", d, 32'd0);
      bus(32'h0000_0000, 32'h0000_00FF, 4'hF, d, lat);
      check("oow_zero_ready", 32'(lat), 32'hFFFF_FFFF);
      check("oow_zero_rdata", d, 32'd0);
      wr(4'h8, 32'h0000_0304, 4'h3);
      wr(4'h8, 32'h0000_AB12, 4'h1);
      rd(4'h8, d);
      check("div_low_byte", d, 32'h0000_0312);
      wr(4'hC, 32'hFFFF_FFFF, 4'hF);
      rd(4'hC, d);
      check("reserved_read", d, 32'd0);
      rd(4'h0, d);
      check("txdata_read", d, 32'd0);
      rd(4'h4, d);
      check("oow_no_push", d, 32'h0000_0002);

      // ---- Divisor zero runs at one cycle per bit ----
      wr(4'h8, 32'd0, 4'h3);
      mon_div = 1;
      clear_frames();
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      wr(4'h0, {24'd0, b}, 4'h1);
      wait_idle(100, n);
      check("div0_frame_end", 32'(n), 32'd10);
      tick(2);
      check_frames(1);

      // ---- Reset mid-frame ----
      wr(4'h8, 32'd8, 4'h3);
      mon_en = 1'b0;
      wr(4'h0, 32'h0000_00A3, 4'h1);
      wr(4'h0, 32'h0000_005A, 4'h1);
      wr(4'h0, 32'h0000_00C3, 4'h1);
      tick(12);
      check("abort_busy", 32'(tx_irq), 32'd0);
      resetn = 1'b0;
      tick(1);
      check("abort_uart_tx", 32'(uart_tx), 32'd1);
      tick(1);
      resetn = 1'b1;
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (uart_tx !== 1'b1) lows++;
      end
      check("abort_line_idle", 32'(lows), 32'd0);
      rd(4'h4, d);
      check("abort_status", d, 32'h0000_0002);
      rd(4'h8, d);
      check("abort_div", d, 32'd868);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
